// File: rtl/pwm_capture_if.sv
// Control and result bundle between a PWM capture block and its consumer.
// The master drives restart and the pin; the slave returns the measurements.
`timescale 1ns/1ps

interface pwm_capture_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 i_clr;
   logic                 i_pwm_in;
   logic [CNT_WIDTH-1:0] o_period;
   logic [CNT_WIDTH-1:0] o_high_time;
   logic                 o_valid;
   logic                 o_overflow;

   modport master (
      output i_clr,
      output i_pwm_in,
      input  o_period,
      input  o_high_time,
      input  o_valid,
      input  o_overflow
   );

   modport slave (
      input  i_clr,
      input  i_pwm_in,
      output o_period,
      output o_high_time,
      output o_valid,
      output o_overflow
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: reports period and high time once per PWM cycle, in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
`timescale 1ns/1ps

module pwm_capture #(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   pwm_capture_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FILL_DEPTH = SYNC_STAGES + 3;
`else
   localparam int FILL_DEPTH = SYNC_STAGES + 1;
`endif

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HIGH,
      LOW
   } captureState_t;

   captureState_t          r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_syncOut;
   logic                   r_s;
   logic                   r_sPrev;
   logic                   r_rise;
   logic                   r_fall;
   logic [FILL_DEPTH-1:0]  r_fill;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [CNT_WIDTH-1:0]   r_highTmp;
   logic [CNT_WIDTH-1:0]   r_period;
   logic [CNT_WIDTH-1:0]   r_highTime;
   logic                   r_valid;
   logic                   r_overflow;

   assign w_syncOut = r_sync[SYNC_STAGES-1];

   // r_fill tracks when the pipeline holds real pin history instead of reset zeros,
   // so a pin that is already high at reset release is never mistaken for low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_sPrev <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_fill  <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.i_pwm_in};
         r_sPrev <= r_s;
         r_rise  <= r_s & ~r_sPrev;
         r_fall  <= ~r_s & r_sPrev;
         r_fill  <= {r_fill[FILL_DEPTH-2:0], 1'b1};
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   logic [1:0] r_hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hist <= '0;
         r_s    <= 1'b0;
      end else begin
         r_hist <= {r_hist[0], w_syncOut};
         if ((w_syncOut == r_hist[0]) && (w_syncOut == r_hist[1])) begin
            r_s <= w_syncOut;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s <= 1'b0;
      end else begin
         r_s <= w_syncOut;
      end
   end
`endif

   // Counter restarts at 0 on each accepted rise, so an edge seen with count N means N+1 cycles.
   // Reaching CNT_MAX means the next edge could not be represented, hence saturation wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_highTmp  <= '0;
         r_period   <= '0;
         r_highTime <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (bus.i_clr) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_highTmp  <= '0;
            r_period   <= '0;
            r_highTime <= '0;
            r_overflow <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (r_fill[FILL_DEPTH-1] && !r_s) begin
                     r_state <= ARMED;
                  end
               end
               ARMED: begin
                  if (r_rise) begin
                     r_count <= '0;
                     r_state <= HIGH;
                  end
               end
               HIGH: begin
                  if (r_count == CNT_MAX) begin
                     r_overflow <= 1'b1;
                     r_count    <= '0;
                     r_state    <= IDLE;
                  end else begin
                     r_count <= r_count + CNT_ONE;
                     if (r_fall) begin
                        r_highTmp <= r_count + CNT_ONE;
                        r_state   <= LOW;
                     end
                  end
               end
               LOW: begin
                  if (r_count == CNT_MAX) begin
                     r_overflow <= 1'b1;
                     r_count    <= '0;
                     r_state    <= IDLE;
                  end else if (r_rise) begin
                     r_period   <= r_count + CNT_ONE;
                     r_highTime <= r_highTmp;
                     r_valid    <= 1'b1;
                     r_count    <= '0;
                     r_state    <= HIGH;
                  end else begin
                     r_count <= r_count + CNT_ONE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.o_period    = r_period;
   assign bus.o_high_time = r_highTime;
   assign bus.o_valid     = r_valid;
   assign bus.o_overflow  = r_overflow;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Input-capture peripheral for the 8-bit AVR-style CPU system; measures a PWM waveform such as the timer's oc0a/oc0b compare outputs.
- Samples one asynchronous pin and reports, once per complete PWM cycle:
  - the period (rising edge to rising edge);
  - the high time (rising edge to falling edge).
- Counts are in clk cycles, with a one-cycle valid strobe.
- Used for self-check of the timer unit and as a loop-back receiver for PWM outputs.

## Interface
- CNT_WIDTH, 16, width of counters and of the period/high_time outputs.
- SYNC_STAGES, 2, flip-flop stages in the pwm_in synchronizer (minimum 2).
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous restart: returns the FSM to IDLE and clears the outputs and overflow.
- pwm_in  input  1  asynchronous PWM pin.
- period  output  CNT_WIDTH  last measured period, in clk cycles.
- high_time  output  CNT_WIDTH  last measured high time, in clk cycles.
- valid  output  1  one-cycle pulse when period/high_time have just been updated.
- overflow  output  1  sticky flag: a counter saturated without an edge.

## Operation
- **Edge detection**
  - pwm_in passes through SYNC_STAGES flops, giving s.
  - rise = s & ~s_prev; fall = ~s & s_prev.
- **FSM states**
  - IDLE: wait for s == 0, then go to ARMED. This prevents a false edge on a pin that is already high.
  - ARMED: on rise, clear the counter and go to HIGH. Nothing is reported.
  - HIGH: counter increments each cycle. On fall, latch high_tmp = cycles since the rise and go to LOW.
  - LOW: counter increments each cycle. On rise:
    - period <= cycles since the previous rise;
    - high_time <= high_tmp;
    - valid pulses;
    - counter restarts;
    - go to HIGH.
- First report comes at the second accepted rising edge after reset/clr; later reports come every rising edge.
- **Arithmetic**
  - The counter is CNT_WIDTH unsigned.
  - Measurable range is 1..2^CNT_WIDTH-1 cycles.
  - There is no modular wrap.
- **Saturation**
  - Applies in HIGH or LOW: if the counter reaches 2^CNT_WIDTH-1 before the expected edge:
    - set overflow;
    - go to IDLE;
    - leave period/high_time holding their previous values;
    - no valid pulse.
  - This covers a pin stuck high and a pin stuck low.
- **Sticky bits**
  - overflow stays set until clr or reset.
  - Measurements continue after an overflow.
- **Priority:** reset > clr > saturation > edge events.
  - clr in the same cycle as rise: clr wins and no valid is produced.

## Timing
- **Reset values:**
  - period = 0, high_time = 0, valid = 0, overflow = 0;
  - FSM = IDLE;
  - synchronizer flops = 0;
  - counter = 0.
- **Latency**
  - valid rises exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples pwm_in high for the closing rising edge.
  - With PWM_CAPTURE_FILTER_EN defined, this latency is SYNC_STAGES+4.
- **Output update**
  - period/high_time change only on the clk edge that asserts valid.
  - They are stable and valid in the valid cycle and hold until the next update.
- **Valid pulse**
  - valid is high for exactly one cycle.
  - There is no handshake and no backpressure; the consumer must sample during valid.
- **Minimum waveform**
  - High and low phases of at least 1 synchronized cycle each are measured correctly.
  - Shorter pin pulses may be lost by sampling.
- **Reset and clr mid-measurement**
  - Asynchronous reset mid-measurement aborts immediately and returns to the reset values.
  - clr takes effect at the next clk edge.

## Configuration
- PWM_CAPTURE_FILTER_EN
  - **Defined:** a glitch filter sits after the synchronizer.
    - s changes only after 3 consecutive identical synchronized samples.
    - Pulses of 1–2 cycles are ignored.
    - All edges are delayed by 2 cycles, so measured period/high_time of clean waveforms are unchanged.
  - **Undefined:** s is the synchronizer output directly.

## Test plan
- **Reset check:** reset high for 10 ns with pwm_in toggling -> all outputs 0 and no valid while reset is high.
- **Steady PWM:** after reset, pwm_in repeats 30 cycles high / 70 cycles low.
  - First valid comes at the second rising edge.
  - Every valid shows period = 100 and high_time = 30.
  - The interval between valid pulses is 100 cycles.
- **Pin high at reset release:** pwm_in = 1 at release, then falls and runs 5 high / 5 low.
  - No valid before the first genuine rise.
  - Thereafter period = 10 and high_time = 5.
- **Overflow:** CNT_WIDTH = 8, pwm_in held high for 300 cycles after a rise.
  - overflow = 1 and no valid.
  - A following 10/20 waveform yields period = 30, high_time = 10 with overflow still 1.
  - clr clears it to 0.
- **clr mid-measurement:** assert clr during LOW, in the cycle of a rise.
  - No valid in that period.
  - period/high_time = 0.
  - The next report arrives two rising edges later with correct values.
- **Filter (PWM_CAPTURE_FILTER_EN defined):** 20/20 waveform with 1-cycle low glitches inside the high phase.
  - period = 40 and high_time = 20.
  - Without the macro, the bench expects the glitch to split the measurement.
